// File: rtl/captura_jogada_if.sv
// Button-capture bundle: enable, raw buttons and clear in, captured move and status pulses out.
interface captura_jogada_if;
  logic       habilita;
  logic [3:0] botoes;
  logic       limpa;
  logic [3:0] jogada;
  logic       jogada_valida;
  logic       jogada_feita;
  logic       multipla;
  logic       timeout;

  modport master (
    output habilita, botoes, limpa,
    input  jogada, jogada_valida, jogada_feita, multipla, timeout
  );

  modport slave (
    input  habilita, botoes, limpa,
    output jogada, jogada_valida, jogada_feita, multipla, timeout
  );
endinterface

// File: rtl/captura_jogada.sv
// Synchronizes and debounces four buttons, holds one accepted one-hot move until cleared; move lands 2+DEBOUNCE_CYCLES edges after the press.
// Optional inactivity pulse on `timeout` when CAPTURA_TIMEOUT_EN is defined; otherwise tied 0.
module captura_jogada #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic            i_clock,
  input  logic            i_reset,
  captura_jogada_if.slave io_cap
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    REGISTRA = 2'd2,
    SOLTAR   = 2'd3
  } state_t;

  state_t        r_state;
  logic [3:0]    r_sinc1;
  logic [3:0]    r_sinc2;
  logic [3:0]    r_cand;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_jogada;
  logic          r_valida;
  logic          r_feita;
  logic          r_multipla;
  logic          w_onehot;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_sinc1 <= 4'd0;
      r_sinc2 <= 4'd0;
    end else begin
      r_sinc1 <= io_cap.botoes;
      r_sinc2 <= r_sinc1;
    end
  end

  assign w_onehot = (r_cand != 4'd0) && ((r_cand & (r_cand - 4'd1)) == 4'd0);

  // A registration on the same edge as limpa is assigned later, so the new move wins.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_cand     <= 4'd0;
      r_cnt      <= '0;
      r_jogada   <= 4'd0;
      r_valida   <= 1'b0;
      r_feita    <= 1'b0;
      r_multipla <= 1'b0;
    end else begin
      r_feita    <= 1'b0;
      r_multipla <= 1'b0;
      if (io_cap.limpa) begin
        r_jogada <= 4'd0;
        r_valida <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (io_cap.habilita && (r_sinc2 != 4'd0)) begin
            r_state <= DEBOUNCE;
            r_cand  <= r_sinc2;
            r_cnt   <= '0;
          end
        end
        DEBOUNCE: begin
          if (!io_cap.habilita || (r_sinc2 == 4'd0)) begin
            r_state <= IDLE;
          end else if (r_sinc2 != r_cand) begin
            r_cand <= r_sinc2;
            r_cnt  <= '0;
          end else if (r_cnt < CNT_LAST) begin
            r_cnt <= r_cnt + 1'b1;
          end else if (w_onehot) begin
            r_state  <= REGISTRA;
            r_jogada <= r_cand;
            r_valida <= 1'b1;
            r_feita  <= 1'b1;
          end else begin
            r_state    <= SOLTAR;
            r_multipla <= 1'b1;
          end
        end
        REGISTRA: r_state <= SOLTAR;
        SOLTAR: begin
          // Held buttons park here so one press yields at most one move.
          if (r_sinc2 == 4'd0) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign io_cap.jogada        = r_jogada;
  assign io_cap.jogada_valida = r_valida;
  assign io_cap.jogada_feita  = r_feita;
  assign io_cap.multipla      = r_multipla;

`ifdef CAPTURA_TIMEOUT_EN
  localparam int            TW      = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] r_to_cnt;
  logic          r_timeout;
  logic          w_ocioso;

  assign w_ocioso = (r_state == IDLE) && io_cap.habilita && !r_valida && (r_sinc2 == 4'd0);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      if (!w_ocioso) begin
        r_to_cnt <= '0;
      end else if (r_to_cnt == TO_LAST) begin
        r_to_cnt  <= '0;
        r_timeout <= 1'b1;
      end else begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
    end
  end

  assign io_cap.timeout = r_timeout;
`else
  // Comparison is constant false; keeps the parameter referenced while the line stays 0.
  assign io_cap.timeout = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_captura_jogada.sv
// Randomized bench for captura_jogada: a run-length reference model queues expected pulses, a negedge monitor pops and compares.
module tb_captura_jogada;

  localparam int D = 4;
  localparam int T = 12;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  captura_jogada_if bus();

  captura_jogada #(
    .DEBOUNCE_CYCLES(D),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .i_clock(clock),
    .i_reset(reset),
    .io_cap (bus.slave)
  );

  typedef struct {
    int         cyc;
    logic [3:0] v;
  } ev_t;

  int  ecnt   = 0;
  int  n_chk  = 0;
  int  n_fail = 0;
  ev_t q_feita[$];
  int  q_mult[$];
  int  q_to[$];

  // Reference state: sampled-button pipeline, current run of identical presses, release lock, held move.
  logic [3:0] m_p1, m_p2, m_run_v, m_jog, s;
  int         m_run_len, m_tc;
  bit         m_lock, m_skip, m_val, acc, idle_now;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, ecnt, act, exp);
    end
  endtask

  always @(posedge clock) begin
    ecnt++;
    if (reset) begin
      m_p1 = 4'd0; m_p2 = 4'd0; m_run_v = 4'd0; m_jog = 4'd0;
      m_run_len = 0; m_tc = 0; m_lock = 0; m_skip = 0; m_val = 0;
    end else begin
      s        = m_p2;
      acc      = 0;
      idle_now = !m_lock && (m_run_len == 0) && bus.habilita && !m_val && (s == 4'd0);
      if (m_lock) begin
        if (m_skip) m_skip = 0;
        else if (s == 4'd0) m_lock = 0;
      end else if (bus.habilita && (s != 4'd0)) begin
        if (m_run_len > 0 && s == m_run_v) m_run_len++;
        else begin
          m_run_v   = s;
          m_run_len = 1;
        end
        if (m_run_len == D + 1) begin
          m_run_len = 0;
          m_lock    = 1;
          if ($countones(s) == 1) begin
            acc    = 1;
            m_skip = 1;
            q_feita.push_back('{ecnt, s});
          end else begin
            q_mult.push_back(ecnt);
          end
        end
      end else begin
        m_run_len = 0;
      end
      if (acc) begin
        m_jog = s;
        m_val = 1;
      end else if (bus.limpa) begin
        m_jog = 4'd0;
        m_val = 0;
      end
`ifdef CAPTURA_TIMEOUT_EN
      if (idle_now) begin
        if (m_tc == T - 1) begin
          m_tc = 0;
          q_to.push_back(ecnt);
        end else m_tc++;
      end else m_tc = 0;
`endif
      m_p2 = m_p1;
      m_p1 = bus.botoes;
    end
  end

  always @(negedge clock) begin
    if (ecnt > 0) begin
      chk("jogada", bus.jogada, m_jog);
      chk("jogada_valida", bus.jogada_valida, m_val);
      while (q_feita.size() > 0 && q_feita[0].cyc < ecnt) begin
        chk("feita_missed", 0, 1);
        void'(q_feita.pop_front());
      end
      if (q_feita.size() > 0 && q_feita[0].cyc == ecnt) begin
        chk("jogada_feita", bus.jogada_feita, 1);
        chk("feita_move", bus.jogada, q_feita[0].v);
        void'(q_feita.pop_front());
      end else begin
        chk("jogada_feita", bus.jogada_feita, 0);
      end
      if (q_mult.size() > 0 && q_mult[0] == ecnt) begin
        chk("multipla", bus.multipla, 1);
        void'(q_mult.pop_front());
      end else begin
        chk("multipla", bus.multipla, 0);
      end
      if (q_to.size() > 0 && q_to[0] == ecnt) begin
        chk("timeout", bus.timeout, 1);
        void'(q_to.pop_front());
      end else begin
        chk("timeout", bus.timeout, 0);
      end
    end
  end

  task automatic drive(input logic h, input logic [3:0] b, input logic l, input int n);
    bus.habilita = h;
    bus.botoes   = b;
    bus.limpa    = l;
    repeat (n) @(negedge clock);
  endtask

  initial begin
    reset        = 1'b1;
    bus.habilita = 1'b1;
    bus.botoes   = 4'd0;
    bus.limpa    = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    drive(1, 4'b0000, 0, 2);

    // Single press held 20 cycles: move appears exactly after edge 6.
    drive(1, 4'b0100, 0, 6);
    chk("lat_before", bus.jogada_valida, 0);
    drive(1, 4'b0100, 0, 1);
    chk("lat_jogada", bus.jogada, 4'b0100);
    chk("lat_feita", bus.jogada_feita, 1);
    drive(1, 4'b0100, 0, 13);
    drive(1, 4'b0000, 0, 6);

    drive(1, 4'b0000, 1, 1);
    drive(1, 4'b0010, 0, 3);
    drive(1, 4'b0000, 0, 8);
    chk("glitch_jogada", bus.jogada, 4'b0000);

    drive(1, 4'b0011, 0, 10);
    drive(1, 4'b0000, 0, 6);

    // Clear on the very edge that registers the next move.
    drive(1, 4'b0001, 0, 8);
    drive(1, 4'b0000, 0, 6);
    drive(1, 4'b1000, 0, 6);
    drive(1, 4'b1000, 1, 1);
    chk("limpa_race_jog", bus.jogada, 4'b1000);
    chk("limpa_race_val", bus.jogada_valida, 1);
    drive(1, 4'b1000, 0, 8);
    drive(1, 4'b0000, 0, 4);
    drive(1, 4'b0000, 1, 1);
    chk("limpa_alone", bus.jogada, 4'b0000);
    drive(1, 4'b0000, 0, 4);

    // Reset while debouncing with the button still held.
    drive(1, 4'b0100, 0, 3);
    reset = 1'b1;
    drive(1, 4'b0100, 0, 1);
    reset = 1'b0;
    chk("rst_jogada", bus.jogada, 0);
    chk("rst_valida", bus.jogada_valida, 0);
    chk("rst_multipla", bus.multipla, 0);
    drive(1, 4'b0100, 0, 12);
    drive(1, 4'b0000, 0, 4);

    // Long idle stretches, interrupted by one disabled cycle.
    drive(1, 4'b0000, 1, 1);
    drive(1, 4'b0000, 0, 30);
    drive(0, 4'b0000, 0, 1);
    drive(1, 4'b0000, 0, 30);

    for (int i = 0; i < 300; i++) begin
      int          r;
      logic [3:0]  v;
      r = $urandom_range(0, 9);
      if (r < 3 || r == 9) v = 4'd0;
      else if (r < 7)      v = 4'(1 << $urandom_range(0, 3));
      else                 v = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 59) == 0) begin
        reset = 1'b1;
        drive(1, v, 0, 1);
        reset = 1'b0;
      end
      drive($urandom_range(0, 19) != 0, v, $urandom_range(0, 5) == 0,
            $urandom_range(1, 9));
    end

    drive(1, 4'b0000, 0, 10);
    chk("feita_drained", q_feita.size(), 0);
    chk("mult_drained", q_mult.size(), 0);
    chk("to_drained", q_to.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/captura_jogada.md
# captura_jogada

Player-input capture stage placed directly upstream of the move comparator. It synchronizes and debounces the four raw button lines and rejects multi-button presses. It registers one accepted move as a 4-bit one-hot code and holds it with a valid flag until the control unit clears it. Its `jogada`/`jogada_valida` outputs drive the comparator's move operand and enable.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronized cycles required to accept a press; legal range ≥1.
- `TIMEOUT_CYCLES`, default 1000: idle cycles before `timeout` pulses; used only with `CAPTURA_TIMEOUT_EN`.
- `clock`  in  1: single clock; all logic rising-edge.
- `reset`  in  1: synchronous, active-high.
- `habilita`  in  1: capture enabled; low forces return to IDLE and blocks new captures.
- `botoes`  in  4: raw asynchronous button lines, active-high.
- `limpa`  in  1: clears the held move.
- `jogada`  out  4: registered one-hot move; 0 when nothing held.
- `jogada_valida`  out  1: level; high while `jogada` holds an unconsumed move.
- `jogada_feita`  out  1: one-cycle pulse when a move is registered.
- `multipla`  out  1: one-cycle pulse when a stable multi-button press is rejected.
- `timeout`  out  1: one-cycle pulse on inactivity; constant 0 without the macro.

## Operation
- `botoes` passes through a 2-flop synchronizer; `sinc` = second flop. The FSM sees only `sinc`.
- Candidate register `cand` (4 bit), stability counter `cnt` (width $clog2(DEBOUNCE_CYCLES)+1).
- States: IDLE, DEBOUNCE, REGISTRA, SOLTAR.
- IDLE: if `habilita` and `sinc`≠0 → DEBOUNCE, `cand`←`sinc`, `cnt`←0. Otherwise stay.
- DEBOUNCE:
  - `habilita`=0 → IDLE.
  - `sinc`=0 → IDLE.
  - `sinc`≠`cand` (non-zero) → stay, `cand`←`sinc`, `cnt`←0.
  - `sinc`=`cand` and `cnt`<DEBOUNCE_CYCLES−1 → `cnt`+1.
  - `sinc`=`cand` and `cnt`=DEBOUNCE_CYCLES−1: if `cand` one-hot → REGISTRA, with `jogada`←`cand` and `jogada_valida`←1 on this edge. Otherwise → SOLTAR, with `multipla` pulsing for the next cycle.
- REGISTRA: `jogada_feita`=1 for one cycle (Moore), then → SOLTAR unconditionally.
- SOLTAR: wait for `sinc`=0, then → IDLE. A held button never produces a second move.
- `limpa`=1 on an edge: `jogada`←0, `jogada_valida`←0. If the same edge registers a new move, the new move wins (`jogada`=`cand`, valid=1).
- A new move registered while `jogada_valida`=1 overwrites `jogada`; no queueing.

## Timing
- Reset: state IDLE, `cand`=0, `cnt`=0, synchronizer flops 0, `jogada`=0, `jogada_valida`=0, `jogada_feita`=0, `multipla`=0, `timeout`=0, timeout counter 0.
- Latency: edge 0 samples the press into flop 1. The FSM enters DEBOUNCE at edge 2. `jogada`/`jogada_valida` update at edge 2+DEBOUNCE_CYCLES. `jogada_feita` is high for the cycle following that edge.
  - Example, D=4: update at edge 6.
- Glitch shorter than DEBOUNCE_CYCLES synchronized cycles: no output activity.
- `reset` mid-operation (any state) returns to reset values on that edge. It takes priority over `limpa`, `habilita`, and timeout.
- `multipla` and `jogada_feita` are never high in the same cycle.

## Configuration
- Macro `CAPTURA_TIMEOUT_EN`.
- Defined: a counter (width $clog2(TIMEOUT_CYCLES)+1) increments every cycle in which state=IDLE, `habilita`=1, `jogada_valida`=0 and `sinc`=0.
  - It clears to 0 whenever any of those conditions is false.
  - At TIMEOUT_CYCLES−1, `timeout` pulses for the next cycle and the counter restarts at 0; the pulse repeats every TIMEOUT_CYCLES idle cycles.
- Undefined: no counter is synthesized; the `timeout` port remains and is tied 0.

## Test plan
- D=4, habilita=1, `botoes`=4'b0100 held 20 cycles from edge 0 → `jogada`=4'b0100 and `jogada_valida`=1 after edge 6. `jogada_feita` is high exactly one cycle. Only one pulse occurs despite the hold; SOLTAR is kept until release.
- `botoes`=4'b0010 for 3 cycles, then 0 → no `jogada_feita`, `jogada`=0, state returns to IDLE.
- `botoes`=4'b0011 held 10 cycles → one `multipla` pulse, `jogada` unchanged, no `jogada_feita`.
- Move 4'b0001 registered; `limpa` on the same edge as the registration of a following move 4'b1000 → `jogada`=4'b1000 and `jogada_valida`=1. A `limpa` alone afterwards → `jogada`=0, valid=0.
- `reset` asserted while in DEBOUNCE with `botoes`=4'b0100 → all outputs 0 next cycle. A capture restarts only after `sinc` is seen again post-reset.
- With `CAPTURA_TIMEOUT_EN`, TIMEOUT_CYCLES=10, habilita=1, no buttons → `timeout` pulses at cycles 10, 20, … after reset release. Dropping `habilita` for one cycle restarts the count. Without the macro, `timeout` stays 0.
